// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline definitions: buffer state encoding and
// the bit positions of the side-effect control bus.
package pipe_stage_buf_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam int HALT   = 0;
    localparam int REGWRT = 1;
    localparam int MEMWRT = 2;
    localparam int MEMEN  = 3;
    localparam int JUMP   = 4;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the stage buffer: payload register
// with load and clear, plus its valid flop.
module pipe_slot
    import pipe_stage_buf_pkg::*;
#(
    parameter int W = 69
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready inter-stage register with optional skid slot,
// flush, side-effect masking and a saturating stall counter.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int SIDE_W = 5,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SIDE_W-1:0] out_side,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int W = DATA_W + SIDE_W;

    state_t st, st_n;

    logic         accept;
    logic         m_load, m_unload, m_from_s;
    logic         s_load, s_unload;
    logic         m_valid, s_valid;
    logic [W-1:0] m_d, m_q, s_q;

    assign accept = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ST_EMPTY;
        else     st <= st_n;
    end

    always_comb begin
        st_n     = st;
        m_load   = 1'b0;
        m_unload = 1'b0;
        m_from_s = 1'b0;
        s_load   = 1'b0;
        s_unload = 1'b0;
        if (flush) begin
            st_n = ST_EMPTY;
        end else begin
            unique case (st)
                ST_EMPTY: begin
                    if (accept) begin
                        m_load = 1'b1;
                        st_n   = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready && accept) begin
                        m_load = 1'b1;
                    end else if (out_ready) begin
                        m_unload = 1'b1;
                        st_n     = ST_EMPTY;
                    end else if (accept && SKID) begin
                        s_load = 1'b1;
                        st_n   = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        m_load   = 1'b1;
                        m_from_s = 1'b1;
                        s_unload = 1'b1;
                        st_n     = ST_FULL;
                    end
                end
                default: st_n = ST_EMPTY;
            endcase
        end
    end

    assign m_d = m_from_s ? s_q : {in_data, in_side};

    pipe_slot #(.W(W)) u_m (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush),
        .load   (m_load),
        .unload (m_unload),
        .d      (m_d),
        .valid  (m_valid),
        .q      (m_q)
    );

    if (SKID) begin : g_skid
        pipe_slot #(.W(W)) u_s (
            .clk    (clk),
            .rst    (rst),
            .clear  (flush),
            .load   (s_load),
            .unload (s_unload),
            .d      ({in_data, in_side}),
            .valid  (s_valid),
            .q      (s_q)
        );
        // Registered ready: depends only on the skid valid flop.
        assign in_ready = ~s_valid;
    end else begin : g_noskid
        logic s_unused;
        assign s_unused = s_load | s_unload;
        assign s_valid  = 1'b0;
        assign s_q      = '0;
        assign in_ready = ~m_valid | out_ready;
    end

    assign out_valid = m_valid;
    assign out_data  = m_q[W-1:SIDE_W];
    assign out_side  = m_q[SIDE_W-1:0] & {SIDE_W{m_valid}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && !flush
                     && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: SKID=1 and SKID=0 builds against
// a queue-based reference plus directed literal checks.
module tb_pipe_stage_buf;

    localparam int DW = 64;
    localparam int SW = 5;
    localparam int CW = 16;

    logic clk, rst, flush, in_valid, out_ready, cnt_clr;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_side;

    logic          ir1, ov1, ir0, ov0;
    logic [DW-1:0] od1, od0;
    logic [SW-1:0] os1, os0;
    logic [CW-1:0] sc1, sc0;

    int total = 0;
    int bad   = 0;

    pipe_stage_buf #(.DATA_W(DW), .SIDE_W(SW), .SKID(1'b1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .in_side(in_side),
        .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_side(os1),
        .cnt_clr(cnt_clr), .stall_cnt(sc1)
    );

    pipe_stage_buf #(.DATA_W(DW), .SIDE_W(SW), .SKID(1'b0), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data), .in_side(in_side),
        .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .out_side(os0),
        .cnt_clr(cnt_clr), .stall_cnt(sc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: a FIFO of capacity 2 (skid) or 1 (no skid).
    logic [DW+SW-1:0] q1[$];
    logic [DW+SW-1:0] q0[$];
    int m_cnt1, m_cnt0;
    int cmax;
    bit rdy1, rdy0;

    initial cmax = (1 << CW) - 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q1.delete();
            q0.delete();
            m_cnt1 = 0;
            m_cnt0 = 0;
        end else begin
            rdy1 = q1.size() < 2;
            rdy0 = (q0.size() == 0) || out_ready;
            if (cnt_clr) m_cnt1 = 0;
            else if (in_valid && !rdy1 && !flush && m_cnt1 < cmax) m_cnt1++;
            if (cnt_clr) m_cnt0 = 0;
            else if (in_valid && !rdy0 && !flush && m_cnt0 < cmax) m_cnt0++;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (q1.size() > 0 && out_ready) void'(q1.pop_front());
                if (in_valid && rdy1) q1.push_back({in_data, in_side});
                if (q0.size() > 0 && out_ready) void'(q0.pop_front());
                if (in_valid && rdy0) q0.push_back({in_data, in_side});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m1_valid", 64'(ov1), 64'(q1.size() > 0));
            check("m1_ready", 64'(ir1), 64'(q1.size() < 2));
            check("m1_cnt", 64'(sc1), 64'(m_cnt1));
            if (q1.size() > 0) begin
                check("m1_data", od1, q1[0][DW+SW-1:SW]);
                check("m1_side", 64'(os1), 64'(q1[0][SW-1:0]));
            end else begin
                check("m1_side0", 64'(os1), 64'd0);
            end
            check("m0_valid", 64'(ov0), 64'(q0.size() > 0));
            check("m0_ready", 64'(ir0),
                  64'((q0.size() == 0) || out_ready));
            check("m0_cnt", 64'(sc0), 64'(m_cnt0));
            if (q0.size() > 0) begin
                check("m0_data", od0, q0[0][DW+SW-1:SW]);
                check("m0_side", 64'(os0), 64'(q0[0][SW-1:0]));
            end else begin
                check("m0_side0", 64'(os0), 64'd0);
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cnt_clr = 1'b0; in_data = '0; in_side = '0;
        cyc; cyc;
        check("rst_valid", 64'(ov1), 64'd0);
        check("rst_data", od1, 64'd0);
        check("rst_ready", 64'(ir1), 64'd1);
        rst = 1'b0;
        cyc;

        // reset mid-stream
        in_valid = 1'b1; in_data = 64'hA5; in_side = 5'h03;
        cyc;
        in_valid = 1'b0;
        check("pre_rst_data", od1, 64'hA5);
        check("pre_rst_side", 64'(os1), 64'h03);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(ov1), 64'd0);
        check("arst_data", od1, 64'd0);
        check("arst_side", 64'(os1), 64'd0);
        check("arst_ready", 64'(ir1), 64'd1);
        cyc;
        rst = 1'b0;
        cyc;

        // streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 64'(i); in_side = 5'(i);
            cyc;
            check("stream_data", od1, 64'(i));
            check("stream_ready", 64'(ir1), 64'd1);
        end
        in_valid = 1'b0;
        cyc;
        check("stream_drain", 64'(ov1), 64'd0);
        check("stream_cnt", 64'(sc1), 64'd0);

        // backpressure with skid
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h11; in_side = 5'h01;
        cyc;
        in_data = 64'h22; in_side = 5'h02;
        cyc;
        check("bp_ready", 64'(ir1), 64'd0);
        in_data = 64'h33; in_side = 5'h04;
        cyc; cyc; cyc;
        check("bp_cnt3", 64'(sc1), 64'd3);
        out_ready = 1'b1;
        #1 check("bp_d11", od1, 64'h11);
        cyc;
        check("bp_d22", od1, 64'h22);
        check("bp_cnt4", 64'(sc1), 64'd4);
        cyc;
        in_valid = 1'b0;
        check("bp_d33", od1, 64'h33);
        cyc;
        cnt_clr = 1'b1;
        cyc;
        cnt_clr = 1'b0;
        check("clr_cnt", 64'(sc1), 64'd0);

        // flush while in SKID state
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h11; in_side = 5'h01;
        cyc;
        in_data = 64'h22; in_side = 5'h02;
        cyc;
        in_data = 64'h33; in_side = 5'h1F; flush = 1'b1;
        cyc;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(ov1), 64'd0);
        check("fl_side", 64'(os1), 64'd0);
        check("fl_data", od1, 64'd0);
        check("fl_ready", 64'(ir1), 64'd1);
        out_ready = 1'b1;
        cyc;
        check("fl_lost", 64'(ov1), 64'd0);

        // single-register build: combinational ready
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h44; in_side = 5'h08;
        cyc;
        check("ns_ready0", 64'(ir0), 64'd0);
        out_ready = 1'b1; in_data = 64'h55; in_side = 5'h10;
        #1 check("ns_ready1", 64'(ir0), 64'd1);
        cyc;
        check("ns_d55", od0, 64'h55);
        in_valid = 1'b0;
        cyc; cyc;

        // counter saturation and clear priority
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h66;
        for (int i = 0; i < (1 << CW) + 5; i++) cyc;
        check("sat_cnt", 64'(sc1), 64'hFFFF);
        cnt_clr = 1'b1;
        cyc;
        cnt_clr = 1'b0;
        check("sat_clr", 64'(sc1), 64'd0);
        cyc;
        check("sat_inc", 64'(sc1), 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc; cyc; cyc;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register, replacing the hand-built enable/flush flop banks between decode and execute (and reusable at IF/ID, EX/MEM).
- Upstream and downstream use a valid/ready handshake instead of a global stall; an optional skid slot makes in_ready a registered signal.
- Side-effect control bits (halt, regWrt, memWrt, memEn, jump) are carried on a separate bus, zeroed on bubbles and flushes.
- Includes a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 64: payload width (next PC, instruction, read data, non-side-effect control).
- SIDE_W, 5: side-effect control width; forced to 0 whenever the slot is invalid.
- SKID, 1: 1 = two-entry skid buffer, in_ready registered; 0 = single register, in_ready combinational.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  squash all held entries (taken branch/jump).
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  this block accepts on in_valid & in_ready.
- in_data  in  DATA_W  upstream payload.
- in_side  in  SIDE_W  upstream side-effect bits.
- out_valid  out  1  main slot holds an entry.
- out_ready  in  1  downstream consumes on out_valid & out_ready.
- out_data  out  DATA_W  main-slot payload.
- out_side  out  SIDE_W  main-slot side bits AND out_valid.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  cycles with in_valid & ~in_ready & ~flush; saturates.

Behaviour:
- Reset (async): state EMPTY, both slots invalid, payload/side registers 0, stall_cnt 0. Thus out_valid=0, out_data=0, out_side=0, in_ready=1.
- Latency: 1 cycle from accept to out_valid in EMPTY. Throughput: 1 entry per cycle when out_ready is held high.
- States for SKID=1: EMPTY (M and S invalid), FULL (M valid), SKID (M and S valid).
  - EMPTY: accept -> M<=in, go to FULL.
  - FULL, out_ready & accept: M<=in, stay FULL.
  - FULL, out_ready & ~accept: go to EMPTY.
  - FULL, ~out_ready & accept: S<=in, go to SKID.
  - FULL, otherwise: hold.
  - SKID: in_ready=0. On out_ready: M<=S, go to FULL. Otherwise hold.
- in_ready (SKID=1): equals ~S_valid, driven directly from a flop. There is no combinational path from out_ready.
- SKID=0: only states EMPTY and FULL exist. in_ready = ~out_valid | out_ready. S is not built.
- Flush: highest priority. Next state is EMPTY and all stored payload/side bits are cleared to 0. An entry presented in the same cycle is dropped, even if in_valid & in_ready.
  - A downstream consume in the flush cycle still completes normally; the current out_* values are visible that cycle.
- out_side is masked combinationally with out_valid, so it is never nonzero while out_valid=0.
- Held entries never change while ~out_ready. This covers payload, side bits and ordering.
- stall_cnt: increments when in_valid & ~in_ready & ~flush, and holds at all-ones.
  - cnt_clr takes priority over increment.
  - The counter is unaffected by flush.
- Ordering is strict FIFO; S is never bypassed by M.

Decomposition:
- Shared pipeline package holds:
  - state encoding: ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2;
  - the default side-effect bit-index constants: HALT=0, REGWRT=1, MEMWRT=2, MEMEN=3, JUMP=4.
- One sub-module, pipe_slot: DATA_W+SIDE_W register with load, clear and async reset, plus a valid flop. It is instanced as M and, when SKID=1, as S.
- FSM, handshake and counter live in the top.

Test Plan:
- Reset mid-stream: with FULL holding data 64'hA5, assert rst asynchronously -> out_valid=0, out_data=0, in_ready=1 immediately (before next edge).
- Streaming: in_valid=1 and out_ready=1 for 8 cycles, data 1..8 -> out_data 1..8 on consecutive cycles starting 1 cycle later, in_ready stays 1, stall_cnt=0.
- Backpressure, SKID=1: out_ready=0, push 0x11 then 0x22 then attempt 0x33.
  - Expected: in_ready=0 after the second accept; stall_cnt counts 1 per blocked cycle.
  - Then release out_ready: out_data 0x11, then 0x22, then 0x33.
- Flush in SKID state with in_side=5'h1F presented the same cycle -> next cycle out_valid=0, out_side=0, in_ready=1; entry 0x33 lost.
- SKID=0 build: out_ready=0 with FULL -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 in the same cycle with back-to-back accept.
- Counter: force 2^CNT_W+3 blocked cycles -> stall_cnt=16'hFFFF; pulse cnt_clr while still blocked -> 0, then 1 the next cycle.
